// File: rtl/ram_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
// The RAM_READER_LOOP_EN macro selects continuous looping sweeps (see ram_stream_reader).
package ram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Output buffer entries; issue is throttled so reads in flight always fit.
    localparam int BUF_DEPTH = 2;

    // Address width that stays legal for a degenerate depth of 1.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_reader_skid.sv
// Two-entry FIFO holding {last, addr, data} words between the RAM and the stream.
// The head entry is presented combinationally from storage registers, so it
// stays stable until it is popped.
module ram_reader_skid
    import ram_reader_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            // Capture pushed word into the entry selected by the write pointer
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_mem[gi] <= '0;
                end else if (w_do_push && (r_wr_ptr == 1'(gi))) begin
                    r_mem[gi] <= i_push_data;
                end
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Sweeps a one-cycle-latency synchronous RAM from address 0 to DEPTH-1 and
// presents each word on a valid/ready stream tagged with address and last flag.
// Optional feature: define RAM_READER_LOOP_EN to sweep continuously until stop.
module ram_stream_reader
    import ram_reader_pkg::*;
#(
    parameter int SIZE  = 1,
    parameter int DEPTH = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_stop,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [addr_width(DEPTH)-1:0] o_ram_address,
    input  logic [SIZE-1:0]              i_ram_read_data,
    output logic [SIZE-1:0]              o_out_data,
    output logic [addr_width(DEPTH)-1:0] o_out_addr,
    output logic                         o_out_last,
    output logic                         o_out_valid,
    input  logic                         i_out_ready
);

    localparam int AW = addr_width(DEPTH);
    localparam int EW = SIZE + AW + 1;
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);

    state_t          r_state;
    logic [AW-1:0]   r_ram_address;
    logic            r_in_flight;
    logic [AW-1:0]   r_fl_addr;
    logic            r_fl_last;
    logic            r_busy;
    logic            r_done;

    logic [EW-1:0]   w_head;
    logic [1:0]      w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [2:0]      w_occ_next;
    logic            w_issue;
    logic            w_at_end;
    logic            w_end_run;
    logic            w_drain_done;

    // The RAM sees r_ram_address at the next edge; the returned word is
    // pushed one edge later, tagged with the address it came from.
    ram_reader_skid #(
        .WIDTH (EW)
    ) u_skid (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_in_flight),
        .i_push_data ({r_fl_last, r_fl_addr, i_ram_read_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign o_out_valid   = !w_empty;
    assign o_out_data    = w_head[SIZE-1:0];
    assign o_out_addr    = w_head[SIZE +: AW];
    assign o_out_last    = w_head[SIZE + AW];
    assign o_ram_address = r_ram_address;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

    assign w_pop      = o_out_valid && i_out_ready;
    // Slots still committed after this cycle's pop; a new read may only be
    // issued while that leaves room in the buffer.
    assign w_occ_next = {1'b0, w_count} + {2'b0, r_in_flight} - {2'b0, w_pop};
    assign w_issue    = (r_state == ST_RUN) && !w_full && (w_occ_next < 3'(BUF_DEPTH));
    assign w_at_end   = (r_ram_address == C_LAST_ADDR);
    assign w_drain_done = !r_in_flight && (w_empty || ((w_count == 2'd1) && w_pop));

`ifdef RAM_READER_LOOP_EN
    logic r_stop_latched;

    // Remember a stop request for the rest of the run
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stop_latched <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_stop_latched <= 1'b0;
        end else if (i_stop) begin
            r_stop_latched <= 1'b1;
        end
    end

    assign w_end_run = r_stop_latched || i_stop;
`else
    logic w_unused_stop;
    assign w_unused_stop = i_stop;
    assign w_end_run     = 1'b1;
`endif

    // Sweep FSM with issue counter, in-flight tracking and registered status
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_ram_address <= '0;
            r_in_flight   <= 1'b0;
            r_fl_addr     <= '0;
            r_fl_last     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_in_flight <= w_issue;
            if (w_issue) begin
                r_fl_addr <= r_ram_address;
                r_fl_last <= w_at_end;
                if (w_at_end) begin
                    r_ram_address <= '0;
                end else begin
                    r_ram_address <= r_ram_address + AW'(1);
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_issue && w_at_end && w_end_run) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side client for the team's single-port synchronous RAM (one-cycle read latency, `address` in, `read_data` out). It sweeps the RAM from address 0 to DEPTH-1 and presents each word on a valid/ready stream. The stream is tagged with its address and a last-of-frame flag. It sits between a frame-buffer RAM and a consumer such as the LED-matrix row driver, and absorbs the RAM latency so the consumer can apply back-pressure freely.

## Interface
- SIZE, 1: width of each RAM word / stream word.
- DEPTH, 1: number of RAM entries swept per frame; DEPTH ≥ 2, not required to be a power of two.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a frame sweep; sampled only in IDLE.
- stop  in  1  request loop termination (used only with RAM_READER_LOOP_EN).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the final word of the run is accepted.
- ram_address  out  $clog2(DEPTH)  registered address driven to the RAM.
- ram_read_data  in  SIZE  RAM output, valid the cycle after ram_address.
- out_data  out  SIZE  stream word.
- out_addr  out  $clog2(DEPTH)  RAM address the word came from.
- out_last  out  1  high with the word from address DEPTH-1.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.

## Operation
- Reset values: busy 0, done 0, ram_address 0, out_data 0, out_addr 0, out_last 0, out_valid 0. FSM in IDLE, buffer empty, in-flight flag clear.
- FSM states:
  - IDLE: start → RUN.
  - RUN: issue addresses. After DEPTH-1 is issued, either wrap or go to DRAIN.
  - DRAIN: no new issues. When the buffer is empty and no read is in flight → IDLE with done pulse.
- Issue rule: an address is issued in a cycle only if (buffer occupancy + in-flight reads − pop this cycle) < 2. The 2-entry buffer can never overflow.
- Each issued read sets an in-flight flag. The next cycle, ram_read_data is pushed into the buffer with its address tag and last flag.
- Address increments by 1 per issue. Wrap from DEPTH-1 to 0 uses an explicit compare, not modulo arithmetic.
- Stream rule: no word is dropped, duplicated or reordered under any out_ready pattern. out_data, out_addr and out_last are held stable while out_valid && !out_ready.
- start while busy: ignored.
- stop outside a looping run: ignored.
- Reset mid-run: immediate return to reset values. The in-flight read is discarded.
- The block never writes the RAM. The parent ties the RAM write_en low or muxes it.

## Timing
- start sampled high at edge N. ram_address = 0 from N+1; data captured at N+2; out_valid first high in cycle N+3.
- With out_ready held high: one word per cycle, so DEPTH words occupy cycles N+3 … N+2+DEPTH.
- done pulses in the cycle after the last word's handshake; busy drops in that same cycle.
- out_ready deasserted for k cycles stalls the stream by exactly k cycles. Issue resumes the cycle after a pop frees a slot.

## Configuration
- RAM_READER_LOOP_EN defined:
  - RUN wraps to address 0 after DEPTH-1 and sweeps continuously (display refresh).
  - stop is latched while busy. The current frame completes through DEPTH-1, then DRAIN follows; done pulses after that frame's last word.
- Not defined:
  - stop is unused.
  - Every run is a single frame: RUN → DRAIN after DEPTH-1 is issued.

## Structure
- Package ram_reader_pkg:
  - FSM state enum (IDLE, RUN, DRAIN).
  - Constant BUF_DEPTH = 2.
- Sub-module ram_reader_skid: 2-entry FIFO holding {last, addr, data}. Provides push/pop, occupancy count and full/empty flags. The top level owns the FSM and issue logic.

## Test plan
All scenarios use SIZE=8, DEPTH=8, RAM preloaded with ram[i] = 0x10+i.
- Reset release, start pulse at edge 10, out_ready=1 → out_valid first in cycle 13. Data 0x10…0x17 one per cycle, out_last only on 0x17. done pulse in cycle 21, then busy=0.
- out_ready toggling 1,0,0,1,… pseudo-randomly → exactly 0x10…0x17 in order, no repeats. Outputs stable while stalled. Buffer occupancy never exceeds 2.
- start re-asserted during a run → ignored, single frame of 8 words, one done pulse.
- rst asserted mid-frame after word 0x13 → all outputs return to reset values immediately. A subsequent start yields a fresh 0x10…0x17.
- With RAM_READER_LOOP_EN: start, let 2.5 frames pass, pulse stop during the third frame → the sequence wraps 0x17→0x10 seamlessly. The third frame completes through 0x17 and done pulses once.
- Without RAM_READER_LOOP_EN: stop held high throughout a run → no effect; the frame completes normally.
